// File: rtl/pll_lock_sequencer.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for a stable lock with
// timeout retries, and holds the video pipeline in reset until lock is trusted.
module pll_lock_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 270000,
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned MAX_RETRIES         = 7,
    localparam int unsigned RETRY_W            = $clog2(MAX_RETRIES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lock_i,
    input  logic               restart,
    output logic               pll_reset,
    output logic               sys_reset,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count,
    output logic [7:0]         lock_loss_count
);

    localparam int unsigned STB_W   = $clog2(LOCK_STABLE_CYCLES);
    localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT_CYCLES);
    localparam int unsigned PRS_W   = $clog2(PLL_RESET_CYCLES);
    localparam int unsigned MAX1_W  = (STB_W > TMO_W) ? STB_W : TMO_W;
    localparam int unsigned CNT_W   = (MAX1_W > PRS_W) ? MAX1_W : PRS_W;

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_lock_meta;
    logic               r_lock_s;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [7:0]         w_loss_nxt;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= lock_i;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = retry_count;
        w_loss_nxt  = lock_loss_count;

        if (restart) begin
            w_state_nxt = ST_RESET_PLL;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_cnt == CNT_W'(PLL_RESET_CYCLES - 1)) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still wins.
                    if (r_lock_s) begin
                        w_state_nxt = ST_STABILIZE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        w_cnt_nxt = '0;
                        if (retry_count == RETRY_W'(MAX_RETRIES)) begin
                            w_state_nxt = ST_FAULT;
                        end else begin
                            w_state_nxt = ST_RESET_PLL;
                            w_retry_nxt = retry_count + RETRY_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_STABILIZE: begin
                    if (!r_lock_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // Lock loss re-enters WAIT_LOCK without pulsing the PLL reset.
                    w_cnt_nxt = '0;
                    if (!r_lock_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_retry_nxt = '0;
                        if (lock_loss_count != 8'hFF) begin
                            w_loss_nxt = lock_loss_count + 8'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_RESET_PLL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State register; outputs decoded from next state so they move with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_RESET_PLL;
            r_cnt           <= '0;
            retry_count     <= '0;
            lock_loss_count <= 8'd0;
            pll_reset       <= 1'b1;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
            fault           <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            retry_count     <= w_retry_nxt;
            lock_loss_count <= w_loss_nxt;
            pll_reset       <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAULT);
            sys_reset       <= (w_state_nxt != ST_RUN);
            ready           <= (w_state_nxt == ST_RUN);
            fault           <= (w_state_nxt == ST_FAULT);
        end
    end

endmodule
